// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types for the load/store front-end (access sizes and
//               controller FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic: load extraction with sign/zero
//               extension and sub-word store merge into the read word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_byte_base;
    logic [4:0]  w_half_base;

    assign w_byte_base = {i_addr_lo, 3'b000};
    assign w_half_base = {i_addr_lo[1], 4'b0000};
    assign w_byte      = i_rd_word[w_byte_base +: 8];
    assign w_half      = i_rd_word[w_half_base +: 16];

    always_comb begin
        o_load_data = i_rd_word;
        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? {24'd0, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = i_unsigned ? {16'd0, w_half}
                                              : {{16{w_half[15]}}, w_half};
            default: o_load_data = i_rd_word;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the current memory word.
    always_comb begin
        o_merged_word = i_rd_word;
        case (i_size)
            SZ_BYTE: o_merged_word[w_byte_base +: 8]  = i_wdata[7:0];
            SZ_HALF: o_merged_word[w_half_base +: 16] = i_wdata[15:0];
            default: o_merged_word = i_wdata;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store front-end for a 32-bit word memory with
//               combinational read and synchronous write. Optional error
//               response counter enabled by LSU_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
`ifdef LSU_ERR_CNT_EN
    output logic [15:0]      err_count,
`endif
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [31:0]      mem_wr_data,
    input  logic [31:0]      mem_rd_data
);

    localparam logic [29:0] c_DEPTH_WORDS = 30'(DEPTH);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_wdata;
    logic [WIDTH-1:0] r_mem_addr;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic             w_err;
    logic             w_accept;
    logic             w_rsp_fire;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged_word;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_BYTE: w_err = 1'b0;
            SZ_HALF: w_err = req_addr[0];
            SZ_WORD: w_err = |req_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if (req_addr[31:2] >= c_DEPTH_WORDS) begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request fields and the word index are captured at acceptance so the
    // memory address is stable from a register during ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 32'd0;
            r_mem_addr  <= '0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr_lo   <= req_addr[1:0];
            r_wdata     <= req_wdata;
            r_mem_addr  <= req_addr[WIDTH+1:2];
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= w_err;
        end else if (r_state == ST_ACCESS) begin
            r_rsp_rdata <= r_we ? 32'd0 : w_load_data;
        end
    end

    lsu_align u_align (
        .i_size        (r_size),
        .i_unsigned    (r_unsigned),
        .i_addr_lo     (r_addr_lo),
        .i_rd_word     (mem_rd_data),
        .i_wdata       (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    // Gating with rst_n suppresses a store caught in ACCESS by reset.
    assign mem_wr_en   = (r_state == ST_ACCESS) && r_we && rst_n;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = w_merged_word;
    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

`ifdef LSU_ERR_CNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= 16'd0;
        end else if (w_rsp_fire && r_rsp_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_rsp_fire;
`endif

endmodule : lsu_mem_ctrl
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed self-checking bench for lsu_mem_ctrl with a memory
//               model and an expected-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 256;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_wr_data;
    logic [31:0]      mem_rd_data;
`ifdef LSU_ERR_CNT_EN
    logic [15:0]      err_count;
`endif

    logic [31:0] mem [DEPTH];
    int          wr_cnt;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int checks;
    int errors;

    lsu_mem_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
`ifdef LSU_ERR_CNT_EN
        .err_count    (err_count),
`endif
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt        = wr_cnt + 1;
            last_wr_addr  = {24'd0, mem_addr};
            last_wr_data  = mem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_wr, input int nstall);
        int          w0;
        int          edges;
        logic [31:0] hold_rd;
        logic        hold_err;
        exp_t        e;
        sb.push_back('{exp_rd, exp_err});
        w0 = wr_cnt;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 1;
        while (!rsp_valid && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency", edges, exp_lat);
        e = sb.pop_front();
        if (rsp_valid) begin
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            hold_rd  = rsp_rdata;
            hold_err = rsp_err;
            for (int i = 0; i < nstall; i++) begin
                @(posedge clk);
                #1;
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rdata", rsp_rdata, hold_rd);
                chk("stall_err", {31'd0, rsp_err}, {31'd0, hold_err});
                chk("stall_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        end
        chk("write_count", wr_cnt - w0, exp_wr);
    endtask

    initial begin
        int w0;
        checks       = 0;
        errors       = 0;
        wr_cnt       = 0;
        last_wr_addr = 32'd0;
        last_wr_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        mem[4]       = 32'h8899AABB;
        mem[255]     = 32'hCAFEF00D;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;

        // we, size, uns, addr, wdata, exp_rd, exp_err, latency, writes, stall
        send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 0);
        send(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0, 0);
        send(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 2, 1, 0);
        chk("st_half_addr", last_wr_addr, 32'd4);
        chk("st_half_data", last_wr_data, 32'h1234AABB);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234AABB, 1'b0, 2, 0, 0);
        send(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        send(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 0);
        send(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        send(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 32'h0, 1'b1, 1, 0, 0);
        send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 0, 0);
        send(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, 0);
        send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 0, 0);
        send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000012, 1'b0, 2, 0, 0);
        send(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF55, 32'h0, 1'b0, 2, 1, 0);
        chk("st_byte_data", last_wr_data, 32'h123455BB);
        send(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 0);
        send(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h01020304, 32'h0, 1'b0, 2, 1, 0);
        chk("st_word_data", mem[255], 32'h01020304);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123455BB, 1'b0, 2, 0, 3);

        // Byte store interrupted by reset while in ACCESS.
        w0 = wr_cnt;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_access_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_access_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_access_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_access_writes", wr_cnt - w0, 32'd0);
        chk("rst_access_word4", mem[4], 32'h123455BB);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123455BB, 1'b0, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lsu_mem_ctrl
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store front-end sitting directly upstream of the data memory (32-bit words, combinational read, single-port synchronous write, no byte enables).
- Accepts byte/half/word requests from execute over a valid/ready handshake.
- Checks alignment and range.
- Performs sub-word stores as a same-cycle read-modify-write.
- Extracts and sign/zero-extends loads.
- Returns results over a valid/ready response channel.

Parameters:
DEPTH, 256, number of 32-bit words in the attached memory
WIDTH, $clog2(DEPTH), memory word-address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (ignored for word/store)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or out-of-range
mem_wr_en  out  1  memory write strobe
mem_addr  out  WIDTH  word index to memory
mem_wr_data  out  32  full word to write
mem_rd_data  in  32  combinational read data for mem_addr

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, mem_addr=0, latched request=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata and evaluate error.
  - Error = size==11, OR half with addr[0]=1, OR word with addr[1:0]!=0, OR addr[31:2] >= DEPTH.
  - Error → RESP with rsp_err=1, rsp_rdata=0.
  - Otherwise → ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr[WIDTH+1:2].
  - Load: rsp_rdata registered from mem_rd_data.
    - Byte: lane addr[1:0], bits lane*8+:8.
    - Half: lane addr[1], bits addr[1]*16+:16.
    - Sign-extend unless unsigned. Word: as-is.
  - Store:
    - mem_wr_en=1 for this cycle only.
    - mem_wr_data = mem_rd_data with the addressed byte replaced by wdata[7:0], or the addressed half replaced by wdata[15:0]; full word stores use wdata.
    - rsp_rdata=0.
  - → RESP.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready, then → IDLE.
- Latency (request accepted at edge N):
  - Normal: rsp_valid visible cycle N+2.
  - Error: rsp_valid visible cycle N+1.
  - Next request accepted no earlier than the cycle after the response handshake.
- Registered vs combinational outputs: mem_wr_en is combinational from state (state==ACCESS && latched we && rst_n). mem_addr is registered at request acceptance.
- Reset mid-operation: rst_n low in any state → IDLE next edge. A store in ACCESS with rst_n low performs no write. No pending response survives reset.
- Stores never write on error. Loads never write.

Optional Feature:
LSU_ERR_CNT_EN:
- When defined: adds output err_count[15:0]. It resets to 0 and increments once per error response handshake, saturating at 0xFFFF.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - size enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum.
- One combinational sub-module, lsu_align, holds load lane extraction with sign/zero extension and store byte/half merge. Its inputs are size, unsigned, addr[1:0], rd_word, wdata; its outputs are load_data and merged_word.

Test Plan:
- Preload word 4 = 0x8899AABB. Load byte addr 0x11:
  - signed → rsp_rdata 0xFFFFFFAA.
  - unsigned → 0x000000AA.
  - rsp_valid at N+2.
- Store half wdata 0xFFFF1234 to addr 0x12 → exactly one mem_wr_en pulse, mem_addr 4, mem_wr_data 0x1234AABB. A following word load returns 0x1234AABB.
- Word load addr 0x13 → rsp_err=1, rsp_rdata 0, rsp_valid at N+1, no mem_wr_en.
- Word store addr 0x400 (DEPTH=256) → rsp_err=1, no write. Size 11 at 0x0 → rsp_err=1.
- Load with rsp_ready low 3 cycles → rsp_valid, rsp_rdata stable, req_ready 0 throughout. Handshake on cycle 4, then req_ready=1.
- Byte store to 0x10 with rst_n driven low during ACCESS → no write (word 4 unchanged), next cycle rsp_valid=0, req_ready=1.
